// File: rtl/uc_sequencer.sv
// Microprogram sequencer: next-address select, loop counter and
// return stack for the microcode ROM address path.
module uc_sequencer #(
  parameter int ADDR_WIDTH  = 11,
  parameter int STACK_DEPTH = 5,
  parameter int COUNT_WIDTH = 11,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [3:0]            instr,
  input  logic                  cond,
  input  logic                  cc_en,
  input  logic [ADDR_WIDTH-1:0] d_in,
  input  logic [ADDR_WIDTH-1:0] r_in,
  input  logic [ADDR_WIDTH-1:0] or_in,
  input  logic                  hold,
  output logic [ADDR_WIDTH-1:0] y,
  output logic                  count_zero,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  stack_err
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] FULL = SPW'(STACK_DEPTH);

  typedef enum logic [3:0] {
    JZ, CJS, JMAP, CJP, PUSH, JSRP, CJC, JRP,
    RFCT, RPCT, CRTN, CJPP, LDCT, LOOP, CONT, TWB
  } op_t;

  op_t                   op;
  logic [ADDR_WIDTH-1:0] upc;
  logic [ADDR_WIDTH-1:0] top;
  logic [ADDR_WIDTH-1:0] y_next;
  logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
  logic [SPW-1:0]        sp;
  logic [SPW-1:0]        sp_m1;
  logic [COUNT_WIDTH-1:0] cnt;
  logic pass, cnt_nz;
  logic push, pop, load, dec, clr;

  assign op     = op_t'(instr);
  assign pass   = ~cc_en | cond;
  assign cnt_nz = (cnt != '0);
  assign sp_m1  = sp - 1'b1;

  always_comb begin
    top = RESET_ADDR;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (sp != '0 && sp_m1 == SPW'(i))
        top = stack[i];
  end

  always_comb begin
    y_next = upc;
    push   = 1'b0;
    pop    = 1'b0;
    load   = 1'b0;
    dec    = 1'b0;
    clr    = 1'b0;
    unique case (op)
      JZ: begin
        y_next = RESET_ADDR;
        clr    = 1'b1;
      end
      CJS: if (pass) begin
        y_next = d_in;
        push   = 1'b1;
      end
      JMAP: y_next = r_in;
      CJP: if (pass) y_next = d_in;
      PUSH: begin
        push = 1'b1;
        load = pass;
      end
      JSRP: begin
        push   = 1'b1;
        y_next = pass ? d_in : r_in;
      end
      CJC: if (pass) y_next = d_in | or_in;
      JRP: y_next = pass ? d_in : r_in;
      RFCT: if (cnt_nz) begin
        y_next = top;
        dec    = 1'b1;
      end else begin
        pop = 1'b1;
      end
      RPCT: if (cnt_nz) begin
        y_next = d_in;
        dec    = 1'b1;
      end
      CRTN: if (pass) begin
        y_next = top;
        pop    = 1'b1;
      end
      CJPP: if (pass) begin
        y_next = d_in;
        pop    = 1'b1;
      end
      LDCT: load = 1'b1;
      LOOP: if (pass) pop = 1'b1;
        else y_next = top;
      CONT: y_next = upc;
      TWB: if (pass) begin
        pop = 1'b1;
      end else if (cnt_nz) begin
        y_next = top;
        dec    = 1'b1;
      end else begin
        y_next = d_in;
        pop    = 1'b1;
      end
      default: y_next = upc;
    endcase
  end

  // y is forced during reset so the ROM sees the reset vector at once
  assign y           = reset_n ? y_next : RESET_ADDR;
  assign count_zero  = ~cnt_nz;
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == FULL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      upc       <= RESET_ADDR;
      sp        <= '0;
      cnt       <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++)
        stack[i] <= '0;
    end else if (!hold) begin
      upc <= y_next + 1'b1;
      if (load)
        cnt <= COUNT_WIDTH'(d_in);
      else if (dec)
        cnt <= cnt - 1'b1;
      if (clr) begin
        sp        <= '0;
        stack_err <= 1'b0;
      end else if (push) begin
        // a full stack keeps its depth and replaces the newest entry
        if (sp == FULL) begin
          stack[STACK_DEPTH-1] <= upc;
          stack_err            <= 1'b1;
        end else begin
          for (int i = 0; i < STACK_DEPTH; i++)
            if (sp == SPW'(i))
              stack[i] <= upc;
          sp <= sp + 1'b1;
        end
      end else if (pop) begin
        if (sp == '0)
          stack_err <= 1'b1;
        else
          sp <= sp - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uc_sequencer.sv
// Bench for uc_sequencer: vector table, directed corner sequences
// and random opcodes against a queue-based reference model.
module tb_uc_sequencer;

  localparam int AW    = 11;
  localparam int CW    = 11;
  localparam int DEPTH = 5;
  localparam int RA    = 0;

  localparam int JZ = 0, CJS = 1, JMAP = 2, CJP = 3;
  localparam int PUSH = 4, JSRP = 5, CJC = 6, JRP = 7;
  localparam int RFCT = 8, RPCT = 9, CRTN = 10, CJPP = 11;
  localparam int LDCT = 12, LOOP = 13, CONT = 14, TWB = 15;

  logic          clock;
  logic          reset_n;
  logic [3:0]    instr;
  logic          cond;
  logic          cc_en;
  logic [AW-1:0] d_in;
  logic [AW-1:0] r_in;
  logic [AW-1:0] or_in;
  logic          hold;
  logic [AW-1:0] y;
  logic          count_zero;
  logic          stack_empty;
  logic          stack_full;
  logic          stack_err;

  int tests;
  int fails;

  uc_sequencer #(
    .ADDR_WIDTH(AW),
    .STACK_DEPTH(DEPTH),
    .COUNT_WIDTH(CW),
    .RESET_ADDR(AW'(RA))
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .instr(instr),
    .cond(cond),
    .cc_en(cc_en),
    .d_in(d_in),
    .r_in(r_in),
    .or_in(or_in),
    .hold(hold),
    .y(y),
    .count_zero(count_zero),
    .stack_empty(stack_empty),
    .stack_full(stack_full),
    .stack_err(stack_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  int m_upc;
  int m_cnt;
  int m_stk[$];
  bit m_err;
  int n_stk[$];
  int n_cnt;
  bit n_err;

  typedef struct {
    int op, c, cc, d, r, o, ey, cz, se;
  } vec_t;
  vec_t tbl[20];

  function automatic vec_t mk(int op, int c, int cc, int d, int r,
                              int o, int ey, int cz, int se);
    vec_t v;
    v.op = op; v.c = c; v.cc = cc; v.d = d; v.r = r;
    v.o = o; v.ey = ey; v.cz = cz; v.se = se;
    return v;
  endfunction

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_upc = RA;
    m_cnt = 0;
    m_stk.delete();
    m_err = 0;
  endtask

  function automatic int m_top();
    return (m_stk.size() != 0) ? m_stk[$] : RA;
  endfunction

  task automatic push_n();
    if (n_stk.size() == DEPTH) begin
      n_stk[DEPTH-1] = m_upc;
      n_err = 1;
    end else begin
      n_stk.push_back(m_upc);
    end
  endtask

  task automatic pop_n();
    if (n_stk.size() == 0) n_err = 1;
    else void'(n_stk.pop_back());
  endtask

  task automatic model(output int ey, input bit commit);
    bit p;
    bit nz;
    int t;
    n_stk = m_stk;
    n_cnt = m_cnt;
    n_err = m_err;
    p  = !cc_en || cond;
    nz = (m_cnt != 0);
    t  = m_top();
    ey = m_upc;
    case (int'(instr))
      JZ:   begin ey = RA; n_stk.delete(); n_err = 0; end
      CJS:  if (p) begin ey = int'(d_in); push_n(); end
      JMAP: ey = int'(r_in);
      CJP:  if (p) ey = int'(d_in);
      PUSH: begin push_n(); if (p) n_cnt = int'(d_in) % (1 << CW); end
      JSRP: begin push_n(); ey = p ? int'(d_in) : int'(r_in); end
      CJC:  if (p) ey = int'(d_in | or_in);
      JRP:  ey = p ? int'(d_in) : int'(r_in);
      RFCT: if (nz) begin ey = t; n_cnt--; end else pop_n();
      RPCT: if (nz) begin ey = int'(d_in); n_cnt--; end
      CRTN: if (p) begin ey = t; pop_n(); end
      CJPP: if (p) begin ey = int'(d_in); pop_n(); end
      LDCT: n_cnt = int'(d_in) % (1 << CW);
      LOOP: if (p) pop_n(); else ey = t;
      CONT: ey = m_upc;
      TWB: begin
        if (p) pop_n();
        else if (nz) begin ey = t; n_cnt--; end
        else begin ey = int'(d_in); pop_n(); end
      end
      default: ey = m_upc;
    endcase
    if (commit && !hold) begin
      m_upc = (ey + 1) % (1 << AW);
      m_stk = n_stk;
      m_cnt = n_cnt;
      m_err = n_err;
    end
  endtask

  task automatic check_model(string tag);
    int ey;
    model(ey, 0);
    check({tag, ".y"}, 32'(y), 32'(ey));
    check({tag, ".cz"}, 32'(count_zero), 32'(m_cnt == 0));
    check({tag, ".se"}, 32'(stack_empty), 32'(m_stk.size() == 0));
    check({tag, ".sf"}, 32'(stack_full), 32'(m_stk.size() == DEPTH));
    check({tag, ".err"}, 32'(stack_err), 32'(m_err));
  endtask

  task automatic drive(int op, int c, int cc, int d, int r, int o, int h);
    instr = 4'(op);
    cond  = 1'(c);
    cc_en = 1'(cc);
    d_in  = AW'(d);
    r_in  = AW'(r);
    or_in = AW'(o);
    hold  = 1'(h);
  endtask

  task automatic go(string tag, int op, int c, int cc, int d, int h);
    drive(op, c, cc, d, 0, 0, h);
    #1;
    check_model(tag);
  endtask

  task automatic step();
    int ey;
    @(posedge clock);
    model(ey, 1);
    @(negedge clock);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    reset_n = 1'b0;
    drive(CJP, 1, 1, 'h123, 0, 0, 0);

    tbl[0]  = mk(CONT, 0, 0, 0, 0, 0, 'h000, 1, 1);
    tbl[1]  = mk(CONT, 0, 0, 0, 0, 0, 'h001, 1, 1);
    tbl[2]  = mk(CONT, 0, 0, 0, 0, 0, 'h002, 1, 1);
    tbl[3]  = mk(CONT, 0, 0, 0, 0, 0, 'h003, 1, 1);
    tbl[4]  = mk(CJP, 1, 1, 'h00F, 0, 0, 'h00F, 1, 1);
    tbl[5]  = mk(CJS, 1, 1, 'h200, 0, 0, 'h200, 1, 1);
    tbl[6]  = mk(CONT, 0, 0, 0, 0, 0, 'h201, 1, 0);
    tbl[7]  = mk(CRTN, 1, 1, 0, 0, 0, 'h010, 1, 0);
    tbl[8]  = mk(CJS, 0, 1, 'h200, 0, 0, 'h011, 1, 1);
    tbl[9]  = mk(LDCT, 0, 0, 3, 0, 0, 'h012, 1, 1);
    tbl[10] = mk(RPCT, 0, 0, 'h050, 0, 0, 'h050, 0, 1);
    tbl[11] = mk(RPCT, 0, 0, 'h050, 0, 0, 'h050, 0, 1);
    tbl[12] = mk(RPCT, 0, 0, 'h050, 0, 0, 'h050, 0, 1);
    tbl[13] = mk(RPCT, 0, 0, 'h050, 0, 0, 'h051, 1, 1);
    tbl[14] = mk(CJC, 1, 1, 'h100, 0, 'h00A, 'h10A, 1, 1);
    tbl[15] = mk(CJC, 0, 1, 'h100, 0, 'h00A, 'h10B, 1, 1);
    tbl[16] = mk(JMAP, 0, 0, 0, 'h7FF, 0, 'h7FF, 1, 1);
    tbl[17] = mk(CONT, 0, 0, 0, 0, 0, 'h000, 1, 1);
    tbl[18] = mk(JRP, 0, 1, 'h300, 'h123, 0, 'h123, 1, 1);
    tbl[19] = mk(CJP, 0, 0, 'h040, 0, 0, 'h040, 1, 1);

    // reset state, y forced to the reset vector
    @(negedge clock);
    @(negedge clock);
    check("rst.y", 32'(y), 32'(RA));
    check("rst.cz", 32'(count_zero), 1);
    check("rst.se", 32'(stack_empty), 1);
    check("rst.sf", 32'(stack_full), 0);
    check("rst.err", 32'(stack_err), 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].c, tbl[i].cc, tbl[i].d, tbl[i].r,
            tbl[i].o, 0);
      #1;
      check($sformatf("tbl%0d.y", i), 32'(y), 32'(tbl[i].ey));
      check($sformatf("tbl%0d.cz", i), 32'(count_zero), 32'(tbl[i].cz));
      check($sformatf("tbl%0d.se", i), 32'(stack_empty), 32'(tbl[i].se));
      check_model($sformatf("tblm%0d", i));
      step();
    end

    // stack overflow and JZ recovery
    go("ovf.jz", JZ, 0, 1, 0, 0);
    check("ovf.jz.y", 32'(y), 0);
    step();
    for (int k = 1; k <= 6; k++) begin
      go("ovf.push", PUSH, 0, 1, 'h3FF, 0);
      check($sformatf("ovf.push%0d.y", k), 32'(y), 32'(k));
      step();
      check($sformatf("ovf.full%0d", k), 32'(stack_full), 32'(k >= 5));
      check($sformatf("ovf.err%0d", k), 32'(stack_err), 32'(k == 6));
    end
    go("ovf.top", LOOP, 0, 1, 0, 0);
    check("ovf.top.y", 32'(y), 6);
    step();
    go("ovf.clr", JZ, 0, 1, 0, 0);
    check("ovf.clr.y", 32'(y), 0);
    step();
    check("ovf.clr.se", 32'(stack_empty), 1);
    check("ovf.clr.err", 32'(stack_err), 0);

    // hold during RFCT, then asynchronous reset mid-loop
    go("hld.push", PUSH, 1, 1, 2, 0);
    check("hld.push.y", 32'(y), 1);
    step();
    go("hld.c0", CONT, 0, 0, 0, 0);
    step();
    go("hld.c1", CONT, 0, 0, 0, 0);
    check("hld.c1.y", 32'(y), 3);
    step();
    for (int k = 0; k < 4; k++) begin
      go("hld.rfct", RFCT, 0, 0, 0, 1);
      check($sformatf("hld.rfct%0d.y", k), 32'(y), 1);
      step();
    end
    go("hld.upc", CONT, 0, 0, 0, 1);
    check("hld.upc.y", 32'(y), 4);
    step();
    go("hld.rel", RFCT, 0, 0, 0, 0);
    check("hld.rel.y", 32'(y), 1);
    step();
    check("hld.rel.cz", 32'(count_zero), 0);
    check("hld.rel.se", 32'(stack_empty), 0);
    go("hld.rpct", CJP, 1, 1, 'h3AA, 0);
    check("hld.pre.y", 32'(y), 'h3AA);
    #2 reset_n = 1'b0;
    #1;
    check("mid.y", 32'(y), 32'(RA));
    check("mid.cz", 32'(count_zero), 1);
    check("mid.se", 32'(stack_empty), 1);
    check("mid.sf", 32'(stack_full), 0);
    check("mid.err", 32'(stack_err), 0);
    @(negedge clock);
    model_reset();
    reset_n = 1'b1;
    go("post", CONT, 0, 0, 0, 0);
    check("post.y", 32'(y), 32'(RA));
    step();

    // random opcodes against the model
    for (int n = 0; n < 3000; n++) begin
      int dv;
      dv = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7)
                                       : $urandom_range(0, (1 << AW) - 1);
      drive($urandom_range(0, 15), $urandom_range(0, 1),
            $urandom_range(0, 1), dv, $urandom_range(0, (1 << AW) - 1),
            $urandom_range(0, (1 << AW) - 1),
            ($urandom_range(0, 7) == 0) ? 1 : 0);
      #1;
      check_model($sformatf("rnd%0d", n));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
